fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each requester's data word and of the FIFO write port.
REQ-002 Parameter NUM_REQ_BITS, default 2: requester index width; NUM_REQ = 1 << NUM_REQ_BITS requesters.
REQ-003 Parameter MAX_BURST, default 4: maximum words written per grant; legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  NUM_REQ  per-requester write request; bit i belongs to requester i.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 fifo_full  input  1  full flag from the shared FIFO.
REQ-009 fifo_write_data  output  DATA_WIDTH  data to FIFO write_data.
REQ-010 fifo_wrtEn  output  1  FIFO write enable.
REQ-011 grant  output  NUM_REQ  registered one-hot (or zero) ownership vector.
REQ-012 accept  output  NUM_REQ  one-hot; bit i high in the cycle requester i's word is written.
REQ-013 active_id  output  NUM_REQ_BITS  index of current owner; 0 when no owner.

Function
REQ-014 The FSM SHALL have two states, IDLE and BURST; grant SHALL be all-zero in IDLE and exactly one-hot in BURST.
REQ-015 IDLE: if req != 0, select a winner by round-robin starting at (last_owner+1) mod NUM_REQ, register grant/active_id, clear beat_count, enter BURST next cycle; no write occurs in the selection cycle (arbitration latency 1 cycle).
REQ-016 BURST: fifo_wrtEn = req[owner] & ~fifo_full, combinational; fifo_write_data = owner's req_data slice; accept = grant & {NUM_REQ{fifo_wrtEn}}.
REQ-017 fifo_wrtEn SHALL never be high while fifo_full is high; accept SHALL be zero whenever fifo_wrtEn is zero.
REQ-018 beat_count SHALL increment on each write in BURST and hold otherwise; its width SHALL hold MAX_BURST-1.
REQ-019 Release SHALL occur when req[owner] is low (no write that cycle) or a write occurs with beat_count == MAX_BURST-1.
REQ-020 fifo_full alone SHALL NOT release; owner, grant and beat_count hold while stalled.
REQ-021 On release, last_owner <= owner; the same cycle's req vector SHALL be searched round-robin from owner+1 (owner checked last); if a winner exists, move to BURST with new grant and beat_count=0 (no idle bubble), else go to IDLE.
REQ-022 A releasing owner whose req is still high regains the grant only if no other requester is asserting req.
REQ-023 MAX_BURST=1 SHALL release after every write.
REQ-024 Changes on req for non-owners SHALL not affect outputs until the next arbitration.

Reset
REQ-025 reset low SHALL immediately (asynchronously) force state IDLE, grant=0, active_id=0, beat_count=0, last_owner=NUM_REQ-1, so requester 0 has top priority after reset.
REQ-026 While reset is low, fifo_wrtEn and accept SHALL be 0, including reset asserted mid-burst; any unwritten words are left to the requester to re-present.
REQ-027 First arbitration SHALL occur on the first rising edge with reset high.

Verification
REQ-028 Reset release, req=4'b1111, fifo_full=0, MAX_BURST=4 -> grant=0001 after one cycle, four writes of requester 0 data, then grant=0010 with no bubble, order 0,1,2,3,0.
REQ-029 Only req[2] high continuously -> bursts of 4 writes back-to-back, grant stays 0100, fifo_wrtEn high every BURST cycle.
REQ-030 Owner 1 after 2 writes, fifo_full=1 for 3 cycles -> fifo_wrtEn=0, accept=0, grant held 0010; after full drops, exactly 2 more writes then release.
REQ-031 Owner 3 drops req after 1 write with req[0] high -> release that cycle, no write, grant=0001 next cycle, last_owner=3.
REQ-032 reset driven low mid-burst between clock edges -> grant=0, fifo_wrtEn=0 immediately; after release, requester 0 wins first.
REQ-033 Random req/fifo_full for 10k cycles -> scoreboard: no write while full, grant one-hot or zero, no burst exceeds MAX_BURST, every persistent requester served within NUM_REQ grants.

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Shared-FIFO write arbitration bus: the requester side (master) presents
// per-requester requests and data plus the FIFO full flag, and the arbiter
// side (slave) returns the FIFO write port and the grant/accept status.
interface fifo_write_arbiter_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REQ_BITS = 2
);
  localparam int NUM_REQ = 1 << NUM_REQ_BITS;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          fifo_full;
  logic [DATA_WIDTH-1:0]         fifo_write_data;
  logic                          fifo_wrtEn;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            accept;
  logic [NUM_REQ_BITS-1:0]       active_id;

  modport master (
    output req, req_data, fifo_full,
    input  fifo_write_data, fifo_wrtEn, grant, accept, active_id
  );

  modport slave (
    input  req, req_data, fifo_full,
    output fifo_write_data, fifo_wrtEn, grant, accept, active_id
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter for a shared FIFO. One requester owns the FIFO
// write port for a burst of up to MAX_BURST words; ownership is handed on
// when the owner stops requesting or finishes its burst, and the next owner
// is chosen in the same cycle so back-to-back bursts have no idle bubble.
// A full FIFO stalls the burst without releasing it.
module fifo_write_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REQ_BITS = 2,
  parameter int MAX_BURST    = 4
) (
  input logic                 clk,
  input logic                 reset,   // asynchronous, active-low
  fifo_write_arbiter_if.slave bus
);
  localparam int NUM_REQ = 1 << NUM_REQ_BITS;
  localparam int BEAT_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [NUM_REQ_BITS-1:0] LAST_ID   = NUM_REQ_BITS'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ_BITS-1:0] owner_q, owner_d;
  logic [NUM_REQ_BITS-1:0] last_owner_q, last_owner_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;

  logic                    owner_req_s;
  logic                    wr_en_s;
  logic                    release_s;
  logic [NUM_REQ_BITS-1:0] search_base_s;
  logic [NUM_REQ_BITS-1:0] cand_s;
  logic                    win_found_s;
  logic [NUM_REQ_BITS-1:0] win_id_s;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [NUM_REQ_BITS-1:0] id);
    logic [NUM_REQ-1:0] oh;
    oh     = {NUM_REQ{1'b0}};
    oh[id] = 1'b1;
    return oh;
  endfunction

  // A write happens only in BURST while the owner requests and the FIFO has room.
  assign owner_req_s = bus.req[owner_q];
  assign wr_en_s     = (state_q == ST_BURST) & owner_req_s & ~bus.fifo_full;
  assign release_s   = (state_q == ST_BURST) &
                       (~owner_req_s | (wr_en_s & (beat_q == LAST_BEAT)));

  // Search starts after the previous owner when idle, after the current one on release.
  assign search_base_s = (state_q == ST_BURST) ? owner_q : last_owner_q;

  // Round-robin pick: walk from lowest to highest priority so the nearest requester wins.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = {NUM_REQ_BITS{1'b0}};
    cand_s      = {NUM_REQ_BITS{1'b0}};
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_s      = search_base_s + NUM_REQ_BITS'(k);
      win_found_s = win_found_s | bus.req[cand_s];
      win_id_s    = bus.req[cand_s] ? cand_s : win_id_s;
    end
  end

  // Next-state logic: arbitration, burst beat counting and release handling.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_d       = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d = ST_BURST;
          grant_d = id_to_onehot(win_id_s);
          owner_d = win_id_s;
          beat_d  = {BEAT_W{1'b0}};
        end else begin
          grant_d = {NUM_REQ{1'b0}};
          owner_d = {NUM_REQ_BITS{1'b0}};
          beat_d  = {BEAT_W{1'b0}};
        end
      end
      ST_BURST: begin
        if (release_s) begin
          last_owner_d = owner_q;
          if (win_found_s) begin
            state_d = ST_BURST;
            grant_d = id_to_onehot(win_id_s);
            owner_d = win_id_s;
            beat_d  = {BEAT_W{1'b0}};
          end else begin
            state_d = ST_IDLE;
            grant_d = {NUM_REQ{1'b0}};
            owner_d = {NUM_REQ_BITS{1'b0}};
            beat_d  = {BEAT_W{1'b0}};
          end
        end else if (wr_en_s) begin
          beat_d = beat_q + BEAT_W'(1);
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {NUM_REQ{1'b0}};
        owner_d = {NUM_REQ_BITS{1'b0}};
        beat_d  = {BEAT_W{1'b0}};
      end
    endcase
  end

  // State registers; reset leaves requester 0 first in line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= {NUM_REQ{1'b0}};
      owner_q      <= {NUM_REQ_BITS{1'b0}};
      last_owner_q <= LAST_ID;
      beat_q       <= {BEAT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_q       <= beat_d;
    end
  end

  assign bus.grant           = grant_q;
  assign bus.active_id       = owner_q;
  assign bus.fifo_wrtEn      = wr_en_s;
  assign bus.accept          = grant_q & {NUM_REQ{wr_en_s}};
  assign bus.fifo_write_data = bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and randomized bench for fifo_write_arbiter (4 requesters,
// 32-bit data). A second instance with MAX_BURST=1 covers single-word bursts.
module tb_fifo_write_arbiter;
  localparam int DW  = 32;
  localparam int NRB = 2;
  localparam int NR  = 4;
  localparam int MB  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  fifo_write_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ_BITS(NRB)) bus ();
  fifo_write_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ_BITS(NRB)) bus1 ();

  fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ_BITS(NRB), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ_BITS(NRB), .MAX_BURST(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // status word: {grant, active_id, fifo_wrtEn, accept}
  logic [10:0] obs_st;
  logic [10:0] obs1_st;
  assign obs_st  = {bus.grant, bus.active_id, bus.fifo_wrtEn, bus.accept};
  assign obs1_st = {bus1.grant, bus1.active_id, bus1.fifo_wrtEn, bus1.accept};

  function automatic logic [10:0] st(input logic [3:0] g, input logic [1:0] id,
                                     input logic we, input logic [3:0] acc);
    return {g, id, we, acc};
  endfunction

  function automatic logic [31:0] dat(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load_data();
    for (int i = 0; i < NR; i++) begin
      bus.req_data[i*DW +: DW]  = dat(i);
      bus1.req_data[i*DW +: DW] = dat(i);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    bus.req        = 4'b0000;
    bus.fifo_full  = 1'b0;
    bus1.req       = 4'b0000;
    bus1.fifo_full = 1'b0;
    load_data();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.req       = 4'b1111;
    bus.fifo_full = 1'b0;
    bus1.req      = 4'b0000;
    bus1.fifo_full = 1'b0;
    load_data();
    #3;
    n_vec++;
    if (obs_st !== st(4'b0000, 2'd0, 1'b0, 4'b0000)) begin
      n_err++;
      $display("FAIL reset_idle: got %b expected %b", obs_st, st(4'b0000, 2'd0, 1'b0, 4'b0000));
    end
    tick();
    tick();
    n_vec++;
    if (obs_st !== st(4'b0000, 2'd0, 1'b0, 4'b0000)) begin
      n_err++;
      $display("FAIL reset_hold: got %b expected %b", obs_st, st(4'b0000, 2'd0, 1'b0, 4'b0000));
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [1:0] o;
    tick();
    reset   = 1'b1;
    bus.req = 4'b1111;
    settle();
    n_vec++;
    if (obs_st !== st(4'b0000, 2'd0, 1'b0, 4'b0000)) begin
      n_err++;
      $display("FAIL rr_select_cycle: got %b expected %b", obs_st, st(4'b0000, 2'd0, 1'b0, 4'b0000));
    end
    for (int n = 0; n < 5; n++) begin
      o = 2'(order[n]);
      for (int b = 0; b < MB; b++) begin
        tick();
        n_vec++;
        if (obs_st !== st(4'b0001 << o, o, 1'b1, 4'b0001 << o)) begin
          n_err++;
          $display("FAIL rr_status burst %0d beat %0d: got %b expected %b", n, b, obs_st,
                   st(4'b0001 << o, o, 1'b1, 4'b0001 << o));
        end
        n_vec++;
        if (bus.fifo_write_data !== dat(int'(o))) begin
          n_err++;
          $display("FAIL rr_data burst %0d beat %0d: got %h expected %h", n, b,
                   bus.fifo_write_data, dat(int'(o)));
        end
      end
    end
  endtask

  task automatic test_single_owner();
    do_reset();
    bus.req = 4'b0100;
    settle();
    n_vec++;
    if (obs_st !== st(4'b0000, 2'd0, 1'b0, 4'b0000)) begin
      n_err++;
      $display("FAIL single_select: got %b expected %b", obs_st, st(4'b0000, 2'd0, 1'b0, 4'b0000));
    end
    for (int c = 0; c < 3 * MB; c++) begin
      tick();
      n_vec++;
      if (obs_st !== st(4'b0100, 2'd2, 1'b1, 4'b0100) || bus.fifo_write_data !== dat(2)) begin
        n_err++;
        $display("FAIL single_burst cycle %0d: got %b/%h expected %b/%h", c, obs_st,
                 bus.fifo_write_data, st(4'b0100, 2'd2, 1'b1, 4'b0100), dat(2));
      end
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    bus.req = 4'b0010;
    settle();
    for (int w = 0; w < 2; w++) begin
      tick();
      n_vec++;
      if (obs_st !== st(4'b0010, 2'd1, 1'b1, 4'b0010)) begin
        n_err++;
        $display("FAIL stall_pre_write %0d: got %b expected %b", w, obs_st, st(4'b0010, 2'd1, 1'b1, 4'b0010));
      end
    end
    for (int s = 0; s < 3; s++) begin
      tick();
      bus.fifo_full = 1'b1;
      settle();
      n_vec++;
      if (obs_st !== st(4'b0010, 2'd1, 1'b0, 4'b0000)) begin
        n_err++;
        $display("FAIL stall_full %0d: got %b expected %b", s, obs_st, st(4'b0010, 2'd1, 1'b0, 4'b0000));
      end
    end
    tick();
    bus.fifo_full = 1'b0;
    bus.req       = 4'b0011;
    settle();
    for (int w = 0; w < 2; w++) begin
      if (w > 0) tick();
      n_vec++;
      if (obs_st !== st(4'b0010, 2'd1, 1'b1, 4'b0010) || bus.fifo_write_data !== dat(1)) begin
        n_err++;
        $display("FAIL stall_post_write %0d: got %b/%h expected %b/%h", w, obs_st,
                 bus.fifo_write_data, st(4'b0010, 2'd1, 1'b1, 4'b0010), dat(1));
      end
    end
    tick();
    n_vec++;
    if (obs_st !== st(4'b0001, 2'd0, 1'b1, 4'b0001) || bus.fifo_write_data !== dat(0)) begin
      n_err++;
      $display("FAIL stall_release: got %b/%h expected %b/%h", obs_st, bus.fifo_write_data,
               st(4'b0001, 2'd0, 1'b1, 4'b0001), dat(0));
    end
  endtask

  task automatic test_early_release();
    do_reset();
    bus.req = 4'b1000;
    settle();
    tick();
    n_vec++;
    if (obs_st !== st(4'b1000, 2'd3, 1'b1, 4'b1000)) begin
      n_err++;
      $display("FAIL early_write: got %b expected %b", obs_st, st(4'b1000, 2'd3, 1'b1, 4'b1000));
    end
    tick();
    bus.req = 4'b0001;
    settle();
    n_vec++;
    if (obs_st !== st(4'b1000, 2'd3, 1'b0, 4'b0000)) begin
      n_err++;
      $display("FAIL early_drop: got %b expected %b", obs_st, st(4'b1000, 2'd3, 1'b0, 4'b0000));
    end
    tick();
    n_vec++;
    if (obs_st !== st(4'b0001, 2'd0, 1'b1, 4'b0001)) begin
      n_err++;
      $display("FAIL early_regrant: got %b expected %b", obs_st, st(4'b0001, 2'd0, 1'b1, 4'b0001));
    end
  endtask

  task automatic test_burst_one();
    logic [1:0] o;
    do_reset();
    bus1.req = 4'b0011;
    settle();
    for (int c = 0; c < 4; c++) begin
      tick();
      o = 2'(c % 2);
      n_vec++;
      if (obs1_st !== st(4'b0001 << o, o, 1'b1, 4'b0001 << o)) begin
        n_err++;
        $display("FAIL burst_one cycle %0d: got %b expected %b", c, obs1_st,
                 st(4'b0001 << o, o, 1'b1, 4'b0001 << o));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.req = 4'b0100;
    settle();
    tick();
    tick();
    n_vec++;
    if (obs_st !== st(4'b0100, 2'd2, 1'b1, 4'b0100)) begin
      n_err++;
      $display("FAIL midrst_pre: got %b expected %b", obs_st, st(4'b0100, 2'd2, 1'b1, 4'b0100));
    end
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if (obs_st !== st(4'b0000, 2'd0, 1'b0, 4'b0000)) begin
      n_err++;
      $display("FAIL midrst_async: got %b expected %b", obs_st, st(4'b0000, 2'd0, 1'b0, 4'b0000));
    end
    bus.req = 4'b1111;
    tick();
    reset = 1'b1;
    settle();
    tick();
    n_vec++;
    if (obs_st !== st(4'b0001, 2'd0, 1'b1, 4'b0001)) begin
      n_err++;
      $display("FAIL midrst_first: got %b expected %b", obs_st, st(4'b0001, 2'd0, 1'b1, 4'b0001));
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       full;
    logic       m_busy;
    logic [1:0] m_owner, m_last, base, w;
    int         m_beat, burst_cnt;
    int         waits[NR];
    logic       e_we, rel, found, unfair;
    logic [3:0] e_g;
    logic [1:0] e_id;
    int         cidx;
    do_reset();
    r = 4'b0000;
    m_busy = 1'b0; m_owner = 2'd0; m_last = 2'd3; m_beat = 0; burst_cnt = 0;
    for (int i = 0; i < NR; i++) waits[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(5) == 0) r[i] = ~r[i];
        bus.req_data[i*DW +: DW] = $urandom();
      end
      full          = ($urandom_range(3) == 0);
      bus.req       = r;
      bus.fifo_full = full;
      settle();
      e_g  = m_busy ? (4'b0001 << m_owner) : 4'b0000;
      e_id = m_busy ? m_owner : 2'd0;
      e_we = m_busy & r[m_owner] & ~full;
      n_vec++;
      if (obs_st !== st(e_g, e_id, e_we, e_we ? e_g : 4'b0000)) begin
        n_err++;
        $display("FAIL rnd_status cycle %0d: got %b expected %b", c, obs_st,
                 st(e_g, e_id, e_we, e_we ? e_g : 4'b0000));
      end
      if (e_we) begin
        n_vec++;
        if (bus.fifo_write_data !== bus.req_data[int'(m_owner)*DW +: DW]) begin
          n_err++;
          $display("FAIL rnd_data cycle %0d: got %h expected %h", c, bus.fifo_write_data,
                   bus.req_data[int'(m_owner)*DW +: DW]);
        end
      end
      n_vec++;
      if ((bus.fifo_wrtEn & bus.fifo_full) !== 1'b0 || !$onehot0(bus.grant)) begin
        n_err++;
        $display("FAIL rnd_safety cycle %0d: wrtEn %b full %b grant %b", c,
                 bus.fifo_wrtEn, bus.fifo_full, bus.grant);
      end
      if (bus.fifo_wrtEn === 1'b1) burst_cnt++;
      n_vec++;
      if (burst_cnt > MB) begin
        n_err++;
        $display("FAIL rnd_burst_len cycle %0d: got %0d writes, limit %0d", c, burst_cnt, MB);
      end
      // reference update for the coming clock edge
      rel  = m_busy & (~r[m_owner] | (e_we & (m_beat == MB - 1)));
      base = m_busy ? m_owner : m_last;
      if (!m_busy || rel) begin
        if (rel) m_last = m_owner;
        found = 1'b0;
        w     = 2'd0;
        for (int k = 1; k <= NR; k++) begin
          cidx = (int'(base) + k) % NR;
          if (!found && r[cidx]) begin
            found = 1'b1;
            w     = 2'(cidx);
          end
        end
        if (found) begin
          m_busy = 1'b1; m_owner = w; m_beat = 0; burst_cnt = 0;
          for (int i = 0; i < NR; i++) begin
            if (i == int'(w)) waits[i] = 0;
            else if (r[i]) waits[i]++;
          end
        end else begin
          m_busy = 1'b0; m_owner = 2'd0; m_beat = 0;
        end
      end else if (e_we) begin
        m_beat++;
      end
      unfair = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (!r[i]) waits[i] = 0;
        if (waits[i] > NR) unfair = 1'b1;
      end
      n_vec++;
      if (unfair) begin
        n_err++;
        $display("FAIL rnd_fairness cycle %0d: waits %0d %0d %0d %0d", c,
                 waits[0], waits[1], waits[2], waits[3]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_owner();
    test_full_stall();
    test_early_release();
    test_burst_one();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // run-time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
